// File: rtl/traffic_controller.sv
// Two-way intersection controller with pedestrian walk phase.
// Lights/walk/phase are Moore outputs registered from the next state; all durations must be >= 1.
module traffic_controller #(
    parameter int GREEN_MIN = 8,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic [2:0] phase
);

    localparam int MAX_A = (GREEN_MIN > YELLOW_T) ? GREEN_MIN : YELLOW_T;
    localparam int MAX_B = (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T;
    localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXP + 1);

    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] LD_GRN = CW'(GREEN_MIN);
    localparam logic [CW-1:0] LD_YEL = CW'(YELLOW_T);
    localparam logic [CW-1:0] LD_RED = CW'(ALLRED_T);
    localparam logic [CW-1:0] LD_WLK = CW'(WALK_T);

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        WALK_A    = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        ALLRED_B  = 3'd6,
        WALK_B    = 3'd7
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ped_q, ped_d;
    logic            expired;
    logic            walk_q_st, walk_d_st;

    function automatic logic [CW-1:0] dur(input state_e s);
        case (s)
            NS_GREEN, EW_GREEN:   dur = LD_GRN;
            NS_YELLOW, EW_YELLOW: dur = LD_YEL;
            ALLRED_A, ALLRED_B:   dur = LD_RED;
            default:              dur = LD_WLK;
        endcase
    endfunction

    function automatic logic [1:0] ns_code(input state_e s);
        case (s)
            NS_GREEN:  ns_code = L_GREEN;
            NS_YELLOW: ns_code = L_YELLOW;
            default:   ns_code = L_RED;
        endcase
    endfunction

    function automatic logic [1:0] ew_code(input state_e s);
        case (s)
            EW_GREEN:  ew_code = L_GREEN;
            EW_YELLOW: ew_code = L_YELLOW;
            default:   ew_code = L_RED;
        endcase
    endfunction

    // Counter sits at 1 once a state's time is up; greens rest there awaiting demand.
    assign expired   = (cnt_q == ONE);
    assign walk_q_st = (state_q == WALK_A) || (state_q == WALK_B);
    assign walk_d_st = (state_d == WALK_A) || (state_d == WALK_B);

    always_comb begin
        state_d = state_q;
        case (state_q)
            NS_GREEN:  if (expired && (ew_car || ped_q)) state_d = NS_YELLOW;
            NS_YELLOW: if (expired) state_d = ALLRED_A;
            ALLRED_A:  if (expired) state_d = ped_q ? WALK_A : EW_GREEN;
            WALK_A:    if (expired) state_d = EW_GREEN;
            EW_GREEN:  if (expired && (ns_car || ped_q)) state_d = EW_YELLOW;
            EW_YELLOW: if (expired) state_d = ALLRED_B;
            ALLRED_B:  if (expired) state_d = ped_q ? WALK_B : NS_GREEN;
            default:   if (expired) state_d = NS_GREEN;
        endcase

        cnt_d = cnt_q;
        if (state_d != state_q) cnt_d = dur(state_d);
        else if (!expired)      cnt_d = cnt_q - ONE;

        // Entering walk serves the request; presses on that edge or during walk are absorbed.
        ped_d = ped_q;
        if (!walk_q_st && walk_d_st) ped_d = 1'b0;
        else if (ped_req && !walk_q_st) ped_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= NS_GREEN;
            cnt_q    <= LD_GRN;
            ped_q    <= 1'b0;
            ns_light <= L_GREEN;
            ew_light <= L_RED;
            walk     <= 1'b0;
            phase    <= 3'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ped_q    <= ped_d;
            ns_light <= ns_code(state_d);
            ew_light <= ew_code(state_d);
            walk     <= walk_d_st;
            phase    <= state_d;
        end
    end

endmodule

// File: tb/tb_traffic_controller.sv
// Directed bench: each step queues the expected post-edge outputs, then pops and checks them.
module tb_traffic_controller;

    logic       clk;
    logic       reset_n;
    logic       ns_car;
    logic       ew_car;
    logic       ped_req;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       walk;
    logic [2:0] phase;

    typedef struct packed {
        logic [2:0] ph;
        logic [1:0] ns;
        logic [1:0] ew;
        logic       wk;
    } obs_t;

    obs_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    traffic_controller #(
        .GREEN_MIN(8), .YELLOW_T(3), .ALLRED_T(2), .WALK_T(5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ns_car(ns_car), .ew_car(ew_car),
        .ped_req(ped_req), .ns_light(ns_light), .ew_light(ew_light),
        .walk(walk), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected lights for a phase, straight from the light map.
    function automatic obs_t exp_of(input logic [2:0] p);
        obs_t o;
        o.ph = p;
        o.ns = 2'b10;
        o.ew = 2'b10;
        o.wk = (p == 3'd3) || (p == 3'd7);
        case (p)
            3'd0: o.ns = 2'b00;
            3'd1: o.ns = 2'b01;
            3'd4: o.ew = 2'b00;
            3'd5: o.ew = 2'b01;
            default: ;
        endcase
        return o;
    endfunction

    task automatic cyc(input string tag, input logic [2:0] p);
        obs_t e, got;
        exp_q.push_back(exp_of(p));
        @(posedge clk);
        #1;
        e   = exp_q.pop_front();
        got = {phase, ns_light, ew_light, walk};
        tests++;
        assert (got === e) else begin
            failed++;
            $error("FAIL %s: got phase=%0d ns=%b ew=%b walk=%b, expected phase=%0d ns=%b ew=%b walk=%b",
                   tag, got.ph, got.ns, got.ew, got.wk, e.ph, e.ns, e.ew, e.wk);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] p, input int n);
        for (int i = 0; i < n; i++) cyc(tag, p);
    endtask

    initial begin
        reset_n = 1'b0; ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0;
        @(negedge clk);

        // Reset state, then idle: NS green rests indefinitely.
        cyc("reset", 3'd0);
        cyc("reset_hold", 3'd0);
        reset_n = 1'b1;
        run("idle50", 3'd0, 50);

        // ew_car from reset: green 0-7, yellow 8-10, all-red 11-12, EW green at 13.
        reset_n = 1'b0; ew_car = 1'b1;
        cyc("rst_ew", 3'd0);
        reset_n = 1'b1;
        run("ew_ns_green", 3'd0, 7);
        run("ew_ns_yellow", 3'd1, 3);
        run("ew_allred_a", 3'd2, 2);
        cyc("ew_green_entry", 3'd4);

        // Both cars: strict 26-cycle alternation, no walk.
        ns_car = 1'b1;
        run("alt_ew_green", 3'd4, 7);
        run("alt_ew_yellow", 3'd5, 3);
        run("alt_allred_b", 3'd6, 2);
        run("alt_ns_green", 3'd0, 8);
        run("alt_ns_yellow", 3'd1, 3);
        run("alt_allred_a", 3'd2, 2);
        run("alt_ew_green2", 3'd4, 8);
        run("alt_ew_yellow2", 3'd5, 3);
        run("alt_allred_b2", 3'd6, 2);
        cyc("alt_ns_green2", 3'd0);

        // One-cycle ped press while NS green rests: late demand exits on the next edge.
        reset_n = 1'b0; ns_car = 1'b0; ew_car = 1'b0;
        cyc("rst_ped", 3'd0);
        reset_n = 1'b1;
        run("ped_rest", 3'd0, 10);
        ped_req = 1'b1;
        cyc("ped_sample", 3'd0);
        ped_req = 1'b0;
        run("ped_yellow", 3'd1, 3);
        run("ped_allred", 3'd2, 2);
        run("ped_walk_a", 3'd3, 5);
        cyc("ped_to_ew", 3'd4);
        run("ped_cleared", 3'd4, 15);

        // Held press through a whole WALK_B yields a single walk.
        ped_req = 1'b1;
        cyc("hold_sample", 3'd4);
        run("hold_yellow", 3'd5, 3);
        run("hold_allred", 3'd6, 2);
        run("hold_walk_b", 3'd7, 5);
        cyc("hold_exit", 3'd0);
        ped_req = 1'b0;
        run("hold_no_rewalk", 3'd0, 20);
        ped_req = 1'b1;
        cyc("new_press", 3'd0);
        ped_req = 1'b0;
        run("new_yellow", 3'd1, 3);
        run("new_allred", 3'd2, 2);
        run("new_walk_a", 3'd3, 5);
        cyc("new_to_ew", 3'd4);

        // Reset during EW yellow wins over every input and clears the pending press.
        ns_car = 1'b1;
        run("pre_ew_green", 3'd4, 7);
        cyc("pre_ew_yellow", 3'd5);
        reset_n = 1'b0; ped_req = 1'b1; ew_car = 1'b1;
        cyc("rst_mid_yellow", 3'd0);
        reset_n = 1'b1; ped_req = 1'b0; ew_car = 1'b0; ns_car = 1'b0;
        run("post_rst_rest", 3'd0, 15);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/traffic_controller.md
TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

Interface
REQ-001 Parameter GREEN_MIN, default 8: minimum cycles a direction holds green.
REQ-002 Parameter YELLOW_T, default 3: cycles of yellow.
REQ-003 Parameter ALLRED_T, default 2: cycles of all-red clearance.
REQ-004 Parameter WALK_T, default 5: cycles of pedestrian walk phase.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-007 ns_car  input  1  car waiting on north-south approach (level).
REQ-008 ew_car  input  1  car waiting on east-west approach (level).
REQ-009 ped_req  input  1  pedestrian button; single-cycle pulse or level.
REQ-010 ns_light  output  2  NS light code: 00 green, 01 yellow, 10 red.
REQ-011 ew_light  output  2  EW light code, same encoding.
REQ-012 walk  output  1  pedestrian walk indication.
REQ-013 phase  output  3  current state encoding, for debug.

Function
REQ-014 States and phase encoding SHALL be: NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, WALK_A=3, EW_GREEN=4, EW_YELLOW=5, ALLRED_B=6, WALK_B=7.
REQ-015 Outputs SHALL be Moore, registered, decoded from state only; code 11 SHALL never be driven.
REQ-016 Light map: NS_GREEN ns=00/ew=10; NS_YELLOW ns=01/ew=10; EW_GREEN ns=10/ew=00; EW_YELLOW ns=10/ew=01; ALLRED_*, WALK_* both 10.
REQ-017 walk SHALL be 1 only in WALK_A/WALK_B.
REQ-018 A down-counter SHALL load on every state entry so each timed state is held exactly its parameter count of cycles.
REQ-019 NS_GREEN SHALL exit to NS_YELLOW after GREEN_MIN cycles elapsed and (ew_car or ped_pending); otherwise it rests in NS_GREEN indefinitely.
REQ-020 EW_GREEN SHALL exit to EW_YELLOW after GREEN_MIN cycles elapsed and (ns_car or ped_pending); otherwise it rests.
REQ-021 Demand arriving after GREEN_MIN has elapsed SHALL cause exit at the next rising edge.
REQ-022 NS_YELLOW->ALLRED_A and EW_YELLOW->ALLRED_B SHALL occur after YELLOW_T cycles unconditionally.
REQ-023 ALLRED_A expiry SHALL go to WALK_A if ped_pending else EW_GREEN; ALLRED_B expiry to WALK_B if ped_pending else NS_GREEN.
REQ-024 WALK_A SHALL go to EW_GREEN, WALK_B to NS_GREEN, after WALK_T cycles.
REQ-025 ped_pending SHALL be set on any edge sampling ped_req=1 outside WALK_*, and cleared on the edge entering WALK_*; ped_req sampled on that entering edge or during WALK_* SHALL be absorbed.
REQ-026 Counter width SHALL hold the largest parameter; parameters SHALL be >=1.
REQ-027 Car inputs SHALL have no effect during yellow, all-red or walk.

Reset
REQ-028 reset_n=0 at a rising edge SHALL force, from that edge: state NS_GREEN, ns_light=00, ew_light=10, walk=0, phase=0, ped_pending=0, counter loaded with GREEN_MIN.
REQ-029 Reset mid-phase (any state) SHALL abandon the phase with no yellow/all-red sequencing and take priority over all other inputs.

Verification
REQ-030 Reset, then no inputs for 50 cycles -> ns_light=00, ew_light=10, walk=0 every cycle.
REQ-031 Reset, ew_car held 1 -> NS green cycles 0-7, NS yellow 8-10, all-red 11-12, EW green from cycle 13.
REQ-032 ns_car and ew_car held 1 -> strict alternation with period 26 cycles (8+3+2 per direction), walk never 1.
REQ-033 One-cycle ped_req during NS_GREEN, no cars -> yellow 3, all-red 2, walk=1 for 5 cycles with both lights 10, then EW_GREEN; ped_pending cleared.
REQ-034 ped_req held 1 through an entire WALK_A -> exactly one walk phase; next walk only after a new request outside WALK_*.
REQ-035 reset_n=0 during EW_YELLOW -> next edge ns_light=00, ew_light=10, phase=0.
